// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// read-latency counter sizing and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MAX_RD_LAT = 7;
  localparam int CNT_W      = $clog2(MAX_RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} lsu_state_t;

  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half select with sign/zero extension,
// and store merge of a byte/half into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Halfword lane uses addr[1] only, so an odd halfword address folds down.
  always_comb begin
    lane_b    = word[{addr_lo, 3'b000} +: 8];
    lane_h    = word[{addr_lo[1], 4'b0000} +: 16];
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'b0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'b0, lane_h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B:    store_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses over a word-wide memory with fixed read
// latency; SB/SH use read-modify-write. Define MISALIGN_TRAP_EN to trap misaligned H/W.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 2,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [2:0]       f3_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      wdata_q;
  logic [31:0]      load_data;
  logic [31:0]      store_word;
  logic             acc_err;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  assign acc_err = !f3_legal(req_write, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign acc_err = !f3_legal(req_write, req_funct3);
`endif

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_lo_q),
    .word       (mem_dout),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_lo_q  <= 2'b00;
      wdata_q    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wr_q      <= req_write;
            f3_q      <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_addr  <= req_addr[ADDR_W+1:2];
            if (acc_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && (req_funct3 == F3_W)) begin
              state     <= S_WR;
              mem_write <= 1'b1;
              mem_din   <= req_wdata;
            end else begin
              // Loads and the read half of SB/SH share the read phase.
              state    <= S_RD;
              mem_read <= 1'b1;
              cnt      <= CNT_W'(MEM_RD_LAT - 1);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_RD: begin
          if (cnt == '0) begin
            mem_read <= 1'b0;
            if (wr_q) begin
              state     <= S_WR;
              mem_write <= 1'b1;
              mem_din   <= store_word;
            end else begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= load_data;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WR: begin
          mem_write  <= 1'b0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: arithmetic reference model + scoreboard with a
// per-cycle response checker, directed vectors pinned to hand-computed values.
module tb_load_store_unit;

  localparam int LAT    = 2;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din, mem_dout;

  load_store_unit #(.MEM_RD_LAT(LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: one registered read stage, which gives LAT=2 against the unit.
  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    int          reads;
    int          writes;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_total = 0, wr_total = 0, rd_base = 0, wr_base = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_read)  rd_total++;
    if (mem_write) wr_total++;
    if (mem_read && mem_write) begin
      n_tests++; n_fail++;
      $display("FAIL rw_overlap: mem_read and mem_write both 1 at cycle %0d", cyc);
    end
    if (!rst_n) begin
      rd_base = rd_total; wr_base = wr_total;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      n_tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== q[0].rdata || resp_err !== q[0].err ||
          rd_total - rd_base != q[0].reads || wr_total - wr_base != q[0].writes) begin
        n_fail++;
        $display("FAIL resp@%0d: valid=%b rdata=%h err=%b rd=%0d wr=%0d expected valid=1 rdata=%h err=%b rd=%0d wr=%0d",
                 cyc, resp_valid, resp_rdata, resp_err, rd_total - rd_base, wr_total - wr_base,
                 q[0].rdata, q[0].err, q[0].reads, q[0].writes);
      end
      rd_base = rd_total; wr_base = wr_total;
      void'(q.pop_front());
    end else if (resp_valid === 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL spurious_resp@%0d: resp_valid=1 expected 0", cyc);
    end
  end

  // Drive one request (starting at a negedge), wait for acceptance, then apply the
  // spec rules to the reference memory and schedule the expected response.
  task automatic issue(input string nm, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit pin, input logic [31:0] lit_rdata, input bit lit_err,
                       input bit track, output int acc);
    exp_t e;
    int idx, sh, hs, lat;
    logic [31:0] w, b, h;
    bit legal;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    acc = -1;
    for (int n = 0; n < 50 && req_ready !== 1'b1; n++) @(negedge clk);
    if (req_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL %s_accept: req_ready=%b expected 1 within 50 cycles", nm, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    idx = int'((addr >> 2) & 32'h3FFF);
    w   = ref_mem[idx];
    sh  = int'(addr & 3) * 8;
    hs  = int'((addr >> 1) & 1) * 16;
    b   = (w >> sh) & 32'hFF;
    h   = (w >> hs) & 32'hFFFF;
    legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
`ifdef MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) legal = 1'b0;
    if (f3 == 3'd2 && addr[1:0] != 2'b00) legal = 1'b0;
`endif
    e.err = !legal; e.rdata = 32'h0; e.reads = 0; e.writes = 0; lat = 1;
    if (legal && !wr) begin
      e.reads = LAT; lat = LAT + 1;
      case (f3)
        3'd0: e.rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'd1: e.rdata = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        3'd4: e.rdata = b;
        3'd5: e.rdata = h;
        default: e.rdata = w;
      endcase
    end else if (legal) begin
      e.writes = 1;
      if (f3 == 3'd2) begin
        ref_mem[idx] = wdata; lat = 2;
      end else begin
        e.reads = LAT; lat = LAT + 2;
        if (f3 == 3'd0) ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
        else            ref_mem[idx] = (w & ~(32'hFFFF << hs)) | ((wdata & 32'hFFFF) << hs);
      end
    end
    e.due = acc + lat - 1;
    if (track) q.push_back(e);
    if (pin) begin
      chk({nm, "_model_rdata"}, e.rdata, lit_rdata);
      chk({nm, "_model_err"}, {31'b0, e.err}, {31'b0, lit_err});
    end
    @(negedge clk);
  endtask

  task automatic gap();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  int a1, a2, wr0;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF; mem[5] = 32'h80017FFF; mem[8] = 32'h11223344;
    mem[12] = 32'hCAFEF00D; mem[20] = 32'h55667788;
    for (int i = 0; i < 16384; i++) ref_mem[i] = mem[i];
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, resp_valid, resp_err, mem_read, mem_write},  32'h0);
    chk("reset_data", resp_rdata | mem_din | {18'b0, mem_addr}, 32'h0);
    rst_n = 1'b1; #1;
    chk("ready_before_clk", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    chk("ready_after_clk", {31'b0, req_ready}, 32'h1);

    issue("lw_10",  1'b0, 3'd2, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1, a1); gap();
    issue("sw_10",  1'b1, 3'd2, 32'h10, 32'h80FF1234, 1'b0, 32'h0,        1'b0, 1'b1, a1); gap();
    issue("lb_13",  1'b0, 3'd0, 32'h13, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b1, a1); gap();
    issue("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0,        1'b1, 32'h00000080, 1'b0, 1'b1, a1); gap();
    issue("lhu_12", 1'b0, 3'd5, 32'h12, 32'h0,        1'b1, 32'h000080FF, 1'b0, 1'b1, a1); gap();
    issue("lh_16",  1'b0, 3'd1, 32'h16, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b1, a1); gap();
    issue("lh_14",  1'b0, 3'd1, 32'h14, 32'h0,        1'b1, 32'h00007FFF, 1'b0, 1'b1, a1); gap();
`ifdef MISALIGN_TRAP_EN
    issue("lw_15",  1'b0, 3'd2, 32'h15, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b1, a1); gap();
`else
    issue("lw_15",  1'b0, 3'd2, 32'h15, 32'h0,        1'b1, 32'h80017FFF, 1'b0, 1'b1, a1); gap();
`endif
    issue("sb_21",  1'b1, 3'd0, 32'h21, 32'h000000AB, 1'b0, 32'h0,        1'b0, 1'b1, a1); gap();
    issue("lw_20",  1'b0, 3'd2, 32'h20, 32'h0,        1'b1, 32'h1122AB44, 1'b0, 1'b1, a1); gap();
`ifdef MISALIGN_TRAP_EN
    issue("sh_31",  1'b1, 3'd1, 32'h31, 32'h0000BEEF, 1'b1, 32'h0,        1'b1, 1'b1, a1); gap();
    issue("lw_30",  1'b0, 3'd2, 32'h30, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b1, a1); gap();
`else
    issue("sh_31",  1'b1, 3'd1, 32'h31, 32'h0000BEEF, 1'b1, 32'h0,        1'b0, 1'b1, a1); gap();
    issue("lw_30",  1'b0, 3'd2, 32'h30, 32'h0,        1'b1, 32'hCAFEBEEF, 1'b0, 1'b1, a1); gap();
`endif
    issue("ld_f3_3", 1'b0, 3'd3, 32'h10, 32'h0,       1'b1, 32'h0,        1'b1, 1'b1, a1); gap();
    issue("st_f3_4", 1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0,       1'b1, 1'b1, a1); gap();

    // Back-to-back with req_valid held across both requests.
    issue("sw_40",  1'b1, 3'd2, 32'h40, 32'h12345678, 1'b0, 32'h0,        1'b0, 1'b1, a1);
    issue("lw_40",  1'b0, 3'd2, 32'h40, 32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1, a2); gap();
    chk("b2b_accept_gap", a2 - a1, 32'd3);
    drain();

    // Reset while an SB is in its read phase.
    wr0 = wr_total;
    issue("sb_50_abort", 1'b1, 3'd0, 32'h50, 32'h00000077, 1'b0, 32'h0, 1'b0, 1'b0, a1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    chk("abort_outputs", {req_ready, resp_valid, mem_read, mem_write}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    chk("abort_no_write", wr_total - wr0, 32'd0);
    chk("abort_mem_word", mem[20], 32'h55667788);
    ref_mem[20] = 32'h55667788;
    issue("lw_50", 1'b0, 3'd2, 32'h50, 32'h0, 1'b1, 32'h55667788, 1'b0, 1'b1, a1); gap();
    drain();
    chk("final_mem_8",  mem[8],  ref_mem[8]);
    chk("final_mem_12", mem[12], ref_mem[12]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
